// File: rtl/vga_fb_scanout.sv
// Framebuffer scan-out for a 320x240 RGB444 image shown 2x upscaled on 640x480.
// Prefetches one source row per line pair into a ping-pong buffer and shares the RAM with a draw client.
module vga_fb_scanout #(
    parameter int FB_W      = 320,
    parameter int FB_H      = 240,
    parameter int DW        = 12,
    parameter int AW        = 17,
    parameter int H_DISPLAY = 640,
    parameter int H_TOTAL   = 800,
    parameter int V_DISPLAY = 480,
    parameter int V_TOTAL   = 525
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pix_rgb,
    output logic          pix_valid,
    output logic          fetch_busy
);

    localparam int CW = $clog2(FB_W);
    localparam logic [AW-1:0] FB_SIZE   = AW'(FB_W * FB_H);
    localparam logic [AW-1:0] ROW_STEP  = AW'(FB_W);
    localparam logic [CW-1:0] COL_LAST  = CW'(FB_W - 1);
    localparam logic [9:0]    H_DISP_L  = 10'(H_DISPLAY);
    localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_DISP_L  = 10'(V_DISPLAY);
    localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;

    state_t        state;
    logic          active;
    logic [CW-1:0] col;
    logic [AW-1:0] base;
    logic [1:0]    slot;
    logic          rd_vld_p1;
    logic [CW-1:0] col_p1;
    logic [DW-1:0] linebuf [0:1][0:FB_W-1];

    logic [9:0]    ln;
    logic          trigger;
    logic          fetch_gnt;
    logic          wr_gnt;

    assign ln      = (y == V_LAST) ? 10'd0 : y + 10'd1;
    assign trigger = (x == 10'd0) && (ln < V_DISP_L) && !ln[0];

    // While both sides request during a fetch, the writer owns every fourth slot.
    assign fetch_gnt = (state == FETCH) && !(wr_valid && slot == 2'd3);
    assign wr_gnt    = wr_valid && ((state != FETCH) || slot == 2'd3);

    always_comb begin
        wr_ready  = wr_gnt;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (fetch_gnt) begin
            mem_addr = base + AW'(col);
        end else if (wr_gnt) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
            mem_we    = (wr_addr < FB_SIZE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            active     <= 1'b0;
            col        <= '0;
            base       <= '0;
            slot       <= 2'd0;
            fetch_busy <= 1'b0;
            rd_vld_p1  <= 1'b0;
        end else begin
            rd_vld_p1 <= fetch_gnt;
            if (state == FETCH && wr_valid)
                slot <= slot + 2'd1;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state      <= FETCH;
                        col        <= '0;
                        slot       <= 2'd0;
                        fetch_busy <= 1'b1;
                        // Rows are fetched in order, so the base just steps by one row.
                        base       <= (ln[9:1] == 9'd0) ? '0 : base + ROW_STEP;
                    end
                end
                FETCH: begin
                    if (fetch_gnt) begin
                        col <= col + CW'(1);
                        if (col == COL_LAST)
                            state <= WAIT;
                    end
                end
                WAIT: begin
                    if (x == H_LAST) begin
                        active     <= ~active;
                        state      <= IDLE;
                        fetch_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read return stage: RAM data arrives one cycle after its address.
    always_ff @(posedge clk) begin
        col_p1 <= col;
        if (rst_n && rd_vld_p1)
            linebuf[~active][col_p1] <= mem_rdata;
    end

    // Scan-out stage: one register between x/y and the pixel outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_valid <= 1'b0;
            pix_rgb   <= '0;
        end else if (x < H_DISP_L && y < V_DISP_L) begin
            pix_valid <= 1'b1;
            pix_rgb   <= linebuf[active][x[9:1]];
        end else begin
            pix_valid <= 1'b0;
            pix_rgb   <= '0;
        end
    end

endmodule
